conv_util_monitor: RTL and testbench



---
 rtl/conv_util_monitor.sv | 263 ++++++++++++++++++++++++++
 tb/tb_conv_util_monitor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_util_monitor.sv
// ---------------------------------------------------------------------------
// conv_util_monitor
//   Per-layer utilisation monitor for the conv dataflow engine. A layer window
//   opens on layer_start and closes on layer_done. While open, the block counts
//   total cycles, busy cycles, the lane-valid sum and weight/input stall cycles.
//   Each closed layer becomes one record in a small first-word-fall-through
//   FIFO that a consumer drains over a valid/ready port.
//
// Ports
//   clk, rst           clock and synchronous active-high reset
//   dataflow_en        conv dataflow enabled this cycle
//   conv_vld           per-lane conv output valid (NUM_LANES bits)
//   weight_req         weight loader request pending
//   input_loader_req   input activation loader request pending
//   layer_start        1-cycle pulse, layer begins
//   layer_done         1-cycle pulse, layer ends
//   is_last_layer      qualifies layer_done: last layer of the network
//   rec_valid/ready    record port handshake
//   rec_*              head record fields (zero while rec_valid=0)
//   active             monitor is inside a layer window (FSM in RUN)
//   drop_cnt           saturating count of records lost to a full FIFO
//   proto_err          sticky start/done protocol violation
//
// Handshake: a record transfers on any cycle where rec_valid & rec_ready are
// both high. rec_valid never drops and rec_* never change while a record is
// presented and not accepted.
// ---------------------------------------------------------------------------
module conv_util_monitor #(
    parameter int NUM_LANES = 9,
    parameter int CNT_W     = 32,
    parameter int SUM_W     = CNT_W + $clog2(NUM_LANES + 1),
    parameter int IDX_W     = 8,
    parameter int FIFO_AW   = 2,
    parameter int DROP_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dataflow_en,
    input  logic [NUM_LANES-1:0] conv_vld,
    input  logic                 weight_req,
    input  logic                 input_loader_req,
    input  logic                 layer_start,
    input  logic                 layer_done,
    input  logic                 is_last_layer,
    output logic                 rec_valid,
    input  logic                 rec_ready,
    output logic [CNT_W-1:0]     rec_cycles,
    output logic [CNT_W-1:0]     rec_busy,
    output logic [SUM_W-1:0]     rec_lane_sum,
    output logic [CNT_W-1:0]     rec_wstall,
    output logic [CNT_W-1:0]     rec_istall,
    output logic [IDX_W-1:0]     rec_layer_idx,
    output logic                 rec_last,
    output logic                 active,
    output logic [DROP_W-1:0]    drop_cnt,
    output logic                 proto_err
);

    localparam int PC_W  = $clog2(NUM_LANES + 1);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [CNT_W-1:0] cycles;
        logic [CNT_W-1:0] busy;
        logic [SUM_W-1:0] lane_sum;
        logic [CNT_W-1:0] wstall;
        logic [CNT_W-1:0] istall;
        logic [IDX_W-1:0] idx;
        logic             last;
    } rec_t;

    state_t           state_q;
    logic             active_q;
    logic             proto_err_q;
    logic [CNT_W-1:0] cycles_q, busy_q, wstall_q, istall_q;
    logic [SUM_W-1:0] lane_sum_q;
    logic [IDX_W-1:0] idx_q;

    // ------------------------------------------------------------------
    // Per-cycle increments and saturating next counts
    // ------------------------------------------------------------------
    logic [PC_W-1:0]  pop_cnt;
    logic             busy_now;
    logic             wstall_now;
    logic             istall_now;
    logic [PC_W-1:0]  lane_add;
    logic [SUM_W:0]   lane_ext;
    logic [CNT_W-1:0] cycles_d, busy_d, wstall_d, istall_d;
    logic [SUM_W-1:0] lane_sum_d;

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            pop_cnt = pop_cnt + PC_W'(conv_vld[i]);
        end
    end

    assign busy_now   = dataflow_en & (|conv_vld);
    // A cycle stalled on both loaders is charged to the weight loader only.
    assign wstall_now = weight_req & ~busy_now;
    assign istall_now = input_loader_req & ~busy_now & ~weight_req;
    assign lane_add   = dataflow_en ? pop_cnt : '0;

    always_comb begin
        cycles_d = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);
        busy_d   = (busy_now && !(&busy_q)) ? busy_q + CNT_W'(1) : busy_q;
        wstall_d = (wstall_now && !(&wstall_q)) ? wstall_q + CNT_W'(1) : wstall_q;
        istall_d = (istall_now && !(&istall_q)) ? istall_q + CNT_W'(1) : istall_q;
        // One extra bit catches the carry so the sum clamps instead of wrapping.
        lane_ext   = {1'b0, lane_sum_q} + (SUM_W + 1)'(lane_add);
        lane_sum_d = lane_ext[SUM_W] ? {SUM_W{1'b1}} : lane_ext[SUM_W-1:0];
    end

    // The closing record already includes the layer_done cycle's activity.
    logic close_evt;
    rec_t rec_new;

    assign close_evt = (state_q == S_RUN) & layer_done;

    always_comb begin
        rec_new.cycles   = cycles_d;
        rec_new.busy     = busy_d;
        rec_new.lane_sum = lane_sum_d;
        rec_new.wstall   = wstall_d;
        rec_new.istall   = istall_d;
        rec_new.idx      = idx_q;
        rec_new.last     = is_last_layer;
    end

    // ------------------------------------------------------------------
    // Layer FSM and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            active_q    <= 1'b0;
            proto_err_q <= 1'b0;
            cycles_q    <= '0;
            busy_q      <= '0;
            lane_sum_q  <= '0;
            wstall_q    <= '0;
            istall_q    <= '0;
            idx_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (layer_done) begin
                        proto_err_q <= 1'b1;
                    end
                    if (layer_start) begin
                        state_q    <= S_RUN;
                        active_q   <= 1'b1;
                        cycles_q   <= '0;
                        busy_q     <= '0;
                        lane_sum_q <= '0;
                        wstall_q   <= '0;
                        istall_q   <= '0;
                    end
                end
                S_RUN: begin
                    if (layer_done || layer_start) begin
                        // Any boundary clears the counters; a start without
                        // a matching done is a protocol error.
                        cycles_q   <= '0;
                        busy_q     <= '0;
                        lane_sum_q <= '0;
                        wstall_q   <= '0;
                        istall_q   <= '0;
                        if (!layer_done) begin
                            proto_err_q <= 1'b1;
                        end
                        if (layer_done) begin
                            idx_q <= is_last_layer ? '0 : idx_q + IDX_W'(1);
                        end
                        if (layer_done && !layer_start) begin
                            state_q  <= S_IDLE;
                            active_q <= 1'b0;
                        end
                    end else begin
                        cycles_q   <= cycles_d;
                        busy_q     <= busy_d;
                        lane_sum_q <= lane_sum_d;
                        wstall_q   <= wstall_d;
                        istall_q   <= istall_d;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Record FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    rec_t               mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic [DROP_W-1:0]  drop_q;
    logic               fifo_full, do_pop, do_push, do_drop;

    assign fifo_full = (count_q == (FIFO_AW + 1)'(DEPTH));
    assign rec_valid = (count_q != '0);
    assign do_pop    = rec_valid & rec_ready;
    // When full, a simultaneous pop frees the head slot, which is exactly
    // the slot the write pointer addresses.
    assign do_push   = close_evt & (~fifo_full | do_pop);
    assign do_drop   = close_evt & fifo_full & ~do_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (FIFO_AW + 1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (FIFO_AW + 1)'(1);
            end
            if (do_drop && !(&drop_q)) begin
                drop_q <= drop_q + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= rec_new;
        end
    end

    rec_t head;
    assign head = mem_q[rd_ptr_q];

    // Storage is not reset, so fields are masked while the FIFO is empty.
    assign rec_cycles    = rec_valid ? head.cycles   : '0;
    assign rec_busy      = rec_valid ? head.busy     : '0;
    assign rec_lane_sum  = rec_valid ? head.lane_sum : '0;
    assign rec_wstall    = rec_valid ? head.wstall   : '0;
    assign rec_istall    = rec_valid ? head.istall   : '0;
    assign rec_layer_idx = rec_valid ? head.idx      : '0;
    assign rec_last      = rec_valid ? head.last     : 1'b0;

    assign active    = active_q;
    assign drop_cnt  = drop_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_conv_util_monitor.sv
module tb_conv_util_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_s = 1'b1;
    logic        dataflow_en = 1'b0;
    logic [8:0]  conv_vld = '0;
    logic        weight_req = 1'b0;
    logic        input_loader_req = 1'b0;
    logic        layer_start = 1'b0;
    logic        layer_done = 1'b0;
    logic        is_last_layer = 1'b0;
    logic        rec_ready = 1'b0;

    // Main instance (default parameters)
    logic        rec_valid;
    logic [31:0] rec_cycles, rec_busy, rec_wstall, rec_istall;
    logic [35:0] rec_lane_sum;
    logic [7:0]  rec_layer_idx;
    logic        rec_last, active, proto_err;
    logic [15:0] drop_cnt;

    // Narrow-counter instance for saturation
    logic        s_valid;
    logic [3:0]  s_cycles, s_busy, s_wstall, s_istall;
    logic [7:0]  s_lane_sum;
    logic [7:0]  s_idx;
    logic        s_last, s_active, s_proto;
    logic [15:0] s_drop;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    conv_util_monitor dut (
        .clk(clk), .rst(rst), .dataflow_en(dataflow_en), .conv_vld(conv_vld),
        .weight_req(weight_req), .input_loader_req(input_loader_req),
        .layer_start(layer_start), .layer_done(layer_done), .is_last_layer(is_last_layer),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_cycles(rec_cycles),
        .rec_busy(rec_busy), .rec_lane_sum(rec_lane_sum), .rec_wstall(rec_wstall),
        .rec_istall(rec_istall), .rec_layer_idx(rec_layer_idx), .rec_last(rec_last),
        .active(active), .drop_cnt(drop_cnt), .proto_err(proto_err)
    );

    conv_util_monitor #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst_s), .dataflow_en(dataflow_en), .conv_vld(conv_vld),
        .weight_req(weight_req), .input_loader_req(input_loader_req),
        .layer_start(layer_start), .layer_done(layer_done), .is_last_layer(is_last_layer),
        .rec_valid(s_valid), .rec_ready(1'b0), .rec_cycles(s_cycles),
        .rec_busy(s_busy), .rec_lane_sum(s_lane_sum), .rec_wstall(s_wstall),
        .rec_istall(s_istall), .rec_layer_idx(s_idx), .rec_last(s_last),
        .active(s_active), .drop_cnt(s_drop), .proto_err(s_proto)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, let the DUT sample it, then return to quiet.
    task automatic step(input logic en, input logic [8:0] vld, input logic wr,
                        input logic ir, input logic st, input logic dn, input logic lst);
        dataflow_en = en; conv_vld = vld; weight_req = wr; input_loader_req = ir;
        layer_start = st; layer_done = dn; is_last_layer = lst;
        @(posedge clk); #1;
        dataflow_en = 0; conv_vld = '0; weight_req = 0; input_loader_req = 0;
        layer_start = 0; layer_done = 0; is_last_layer = 0;
    endtask

    task automatic start_layer();
        step(0, 9'h000, 0, 0, 1, 0, 0);
    endtask

    task automatic pop_rec();
        rec_ready = 1;
        @(posedge clk); #1;
        rec_ready = 0;
    endtask

    task automatic short_layer(input int n);
        start_layer();
        for (int k = 0; k < n - 1; k++) step(1, 9'h001, 0, 0, 0, 0, 0);
        step(1, 9'h001, 0, 0, 0, 1, 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check("rst_valid", rec_valid, 0);
        check("rst_active", active, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_proto", proto_err, 0);
        check("rst_cycles", rec_cycles, 0);

        // 1: full-lane busy layer
        start_layer();
        check("t1_active", active, 1);
        for (int k = 0; k < 9; k++) step(1, 9'h1FF, 0, 0, 0, 0, 0);
        step(1, 9'h1FF, 0, 0, 0, 1, 0);
        check("t1_valid", rec_valid, 1);
        check("t1_cycles", rec_cycles, 10);
        check("t1_busy", rec_busy, 10);
        check("t1_lane", rec_lane_sum, 90);
        check("t1_wstall", rec_wstall, 0);
        check("t1_istall", rec_istall, 0);
        check("t1_idx", rec_layer_idx, 0);
        check("t1_last", rec_last, 0);
        check("t1_inactive", active, 0);
        pop_rec();
        check("t1_popped", rec_valid, 0);

        // 2a: stall accounting
        start_layer();
        step(1, 9'h000, 1, 0, 0, 0, 0);
        step(1, 9'h000, 1, 0, 0, 0, 0);
        step(1, 9'h000, 0, 1, 0, 0, 0);
        step(1, 9'h000, 0, 1, 0, 0, 0);
        step(1, 9'h000, 1, 1, 0, 0, 0);
        step(1, 9'h003, 0, 0, 0, 1, 0);
        check("t2a_cycles", rec_cycles, 6);
        check("t2a_wstall", rec_wstall, 3);
        check("t2a_istall", rec_istall, 2);
        check("t2a_busy", rec_busy, 1);
        check("t2a_lane", rec_lane_sum, 2);
        check("t2a_idx", rec_layer_idx, 1);
        pop_rec();

        // 2b: same, dataflow disabled on the valid cycle
        start_layer();
        step(1, 9'h000, 1, 0, 0, 0, 0);
        step(1, 9'h000, 1, 0, 0, 0, 0);
        step(1, 9'h000, 0, 1, 0, 0, 0);
        step(1, 9'h000, 0, 1, 0, 0, 0);
        step(1, 9'h000, 1, 1, 0, 0, 0);
        step(0, 9'h003, 0, 0, 0, 1, 0);
        check("t2b_busy", rec_busy, 0);
        check("t2b_lane", rec_lane_sum, 0);
        check("t2b_wstall", rec_wstall, 3);
        check("t2b_istall", rec_istall, 2);
        check("t2b_idx", rec_layer_idx, 2);
        pop_rec();

        // 3: backpressure, overflow and ordered drain (layer k lasts k+1 cycles)
        rst = 1; @(posedge clk); #1 rst = 0;
        for (int k = 0; k < 4; k++) begin
            short_layer(k + 1);
            check("t3_hold_cycles", rec_cycles, 1);
            check("t3_hold_idx", rec_layer_idx, 0);
        end
        check("t3_nodrop_yet", drop_cnt, 0);
        short_layer(5);
        check("t3_drop", drop_cnt, 1);
        check("t3_stable", rec_cycles, 1);
        for (int k = 0; k < 4; k++) begin
            check("t3_drain_valid", rec_valid, 1);
            check("t3_drain_idx", rec_layer_idx, 64'(k));
            check("t3_drain_cycles", rec_cycles, 64'(k + 1));
            pop_rec();
        end
        check("t3_empty", rec_valid, 0);

        // 4: saturation on the narrow instance; main instance sees the same layer
        rst_s = 0;
        start_layer();
        for (int k = 0; k < 19; k++) step(1, 9'h1FF, 0, 0, 0, 0, 0);
        step(1, 9'h1FF, 0, 0, 0, 1, 0);
        check("t4_s_valid", s_valid, 1);
        check("t4_s_cycles", s_cycles, 15);
        check("t4_s_busy", s_busy, 15);
        check("t4_s_lane", s_lane_sum, 180);
        check("t4_cycles", rec_cycles, 20);
        check("t4_idx", rec_layer_idx, 5);
        pop_rec();

        // 5: last layer resets index; done in IDLE; start+done back-to-back
        start_layer();
        step(0, 9'h000, 0, 0, 0, 1, 1);
        check("t5_last", rec_last, 1);
        check("t5_last_idx", rec_layer_idx, 6);
        pop_rec();
        short_layer(1);
        check("t5_idx_wrap", rec_layer_idx, 0);
        check("t5_not_last", rec_last, 0);
        pop_rec();
        check("t5_proto_clean", proto_err, 0);
        step(0, 9'h000, 0, 0, 0, 1, 0);
        check("t5_proto", proto_err, 1);
        check("t5_no_rec", rec_valid, 0);
        start_layer();
        step(1, 9'h001, 0, 0, 0, 0, 0);
        step(1, 9'h001, 0, 0, 0, 0, 0);
        step(1, 9'h001, 0, 0, 1, 1, 0);
        check("t5_restart_active", active, 1);
        check("t5_restart_cycles", rec_cycles, 3);
        step(1, 9'h001, 0, 0, 0, 0, 0);
        step(1, 9'h001, 0, 0, 0, 1, 0);

        // 6: reset mid-layer with two records queued
        check("t6_queued", rec_valid, 1);
        check("t6_head_idx", rec_layer_idx, 1);
        start_layer();
        step(1, 9'h1FF, 0, 0, 0, 0, 0);
        rst = 1; @(posedge clk); #1 rst = 0;
        check("t6_rst_valid", rec_valid, 0);
        check("t6_rst_active", active, 0);
        check("t6_rst_proto", proto_err, 0);
        check("t6_rst_drop", drop_cnt, 0);
        short_layer(3);
        check("t6_fresh_valid", rec_valid, 1);
        check("t6_fresh_idx", rec_layer_idx, 0);
        check("t6_fresh_cycles", rec_cycles, 3);
        pop_rec();
        check("t6_empty", rec_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
